i2cmb_bit_ctrl: RTL and testbench

Bit-level I2C engine of the i2cmb controller. It sits directly below the byte-level sequencer and above the open-drain SCL/SDA pads. It turns single bus commands (START, STOP, WRITE bit, READ bit) into four-phase SCL/SDA waveforms timed by a programmable prescaler. It reports completion, the read bit, arbitration loss and bus-busy status, which the byte-level FSM and the environment's I2C monitor consume.

---
 rtl/i2cmb_bit_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_i2cmb_bit_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cmb_bit_ctrl.sv
// i2cmb_bit_ctrl: bit-level I2C engine (START/STOP/WRITE/READ -> 4-phase SCL/SDA)
// Optional: `define I2CMB_CLK_STRETCH_EN to let slaves stretch SCL in PH_B.
//
// Ports:
//   clk_i, rst_i (async, active low)
//   prescale_i   phase length minus one, latched on accept
//   cmd_valid_i / cmd_ready_o / cmd_i / din_i   command handshake
//   done_o, dout_o, arb_lost_o, busy_o         status
//   scl_i, sda_i  pad inputs (2-flop synchronised)
//   scl_oe_o, sda_oe_o  1 = pull line low
module i2cmb_bit_ctrl #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_i,
  input  logic                  din_i,
  output logic                  done_o,
  output logic                  dout_o,
  output logic                  arb_lost_o,
  output logic                  busy_o,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_oe_o,
  output logic                  sda_oe_o
);

  typedef enum logic [2:0] {
    IDLE, PH_A, PH_B, PH_C, PH_D
  } state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  state_t                r_state;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [PRESCALE_W-1:0] r_pre;
  logic [1:0]            r_cmd;
  logic                  r_din;
  logic                  r_scl_oe;
  logic                  r_sda_oe;
  logic                  r_done;
  logic                  r_dout;
  logic                  r_arb;
  logic                  r_busy;
  logic                  r_scl_s1;
  logic                  r_scl_s2;
  logic                  r_sda_s1;
  logic                  r_sda_s2;
  logic                  r_sda_d;

  logic w_hold;
  logic w_arb;

  // {scl_oe, sda_oe} for a command in a given phase
  function automatic logic [1:0] f_drive(
    input logic [1:0] c,
    input logic       d,
    input state_t     ph
  );
    logic [1:0] v;
    v = 2'b00;
    unique case (c)
      CMD_START: v = {ph == PH_D, ph == PH_C || ph == PH_D};
      CMD_STOP:  v = {ph == PH_A, ph == PH_A || ph == PH_B};
      CMD_WRITE: v = {ph == PH_A || ph == PH_D, ~d};
      default:   v = {ph == PH_A || ph == PH_D, 1'b0};
    endcase
    return v;
  endfunction

`ifdef I2CMB_CLK_STRETCH_EN
  // SCL high phase only counts once the bus really shows SCL high
  assign w_hold = (r_state == PH_B) && !r_scl_s2;
`else
  assign w_hold = 1'b0;
`endif

  // we released SDA for a 1 but someone else holds it low
  assign w_arb = (r_cmd == CMD_WRITE) && r_din && !r_sda_s2;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_pre    <= '0;
      r_cmd    <= CMD_START;
      r_din    <= 1'b0;
      r_scl_oe <= 1'b0;
      r_sda_oe <= 1'b0;
      r_done   <= 1'b0;
      r_dout   <= 1'b0;
      r_arb    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_arb  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_cmd   <= cmd_i;
            r_din   <= din_i;
            r_pre   <= prescale_i;
            r_cnt   <= prescale_i;
            r_state <= PH_A;
            {r_scl_oe, r_sda_oe} <= f_drive(cmd_i, din_i, PH_A);
          end
        end
        default: begin
          if (!w_hold) begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - ONE;
            end else begin
              r_cnt <= r_pre;
              case (r_state)
                PH_A: begin
                  r_state <= PH_B;
                  {r_scl_oe, r_sda_oe} <= f_drive(r_cmd, r_din, PH_B);
                end
                PH_B: begin
                  r_state <= PH_C;
                  {r_scl_oe, r_sda_oe} <= f_drive(r_cmd, r_din, PH_C);
                end
                PH_C: begin
                  if (r_cmd[1]) r_dout <= r_sda_s2;
                  if (w_arb) begin
                    r_state  <= IDLE;
                    r_cnt    <= '0;
                    r_done   <= 1'b1;
                    r_arb    <= 1'b1;
                    r_scl_oe <= 1'b0;
                    r_sda_oe <= 1'b0;
                  end else begin
                    r_state <= PH_D;
                    {r_scl_oe, r_sda_oe} <= f_drive(r_cmd, r_din, PH_D);
                  end
                end
                default: begin
                  // line levels of PH_D are kept while idle
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  // synchronisers and START/STOP detection for any master on the bus
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
      if (r_scl_s2 && r_sda_d && !r_sda_s2)
        r_busy <= 1'b1;
      else if (r_scl_s2 && !r_sda_d && r_sda_s2)
        r_busy <= 1'b0;
    end
  end

  assign cmd_ready_o = (r_state == IDLE);
  assign done_o      = r_done;
  assign dout_o      = r_dout;
  assign arb_lost_o  = r_arb;
  assign busy_o      = r_busy;
  assign scl_oe_o    = r_scl_oe;
  assign sda_oe_o    = r_sda_oe;

endmodule

// File: tb/tb_i2cmb_bit_ctrl.sv
// tb_i2cmb_bit_ctrl: directed scoreboard bench for i2cmb_bit_ctrl
// open-drain pads modelled from the OE outputs plus external pull-downs
module tb_i2cmb_bit_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] prescale_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_i;
  logic        din_i;
  logic        done_o;
  logic        dout_o;
  logic        arb_lost_o;
  logic        busy_o;
  logic        scl_i;
  logic        sda_i;
  logic        scl_oe_o;
  logic        sda_oe_o;

  logic ext_scl_lo = 1'b0;
  logic ext_sda_lo = 1'b0;

  assign scl_i = ~scl_oe_o & ~ext_scl_lo;
  assign sda_i = ~sda_oe_o & ~ext_sda_lo;

  i2cmb_bit_ctrl #(.PRESCALE_W(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .prescale_i  (prescale_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_i       (cmd_i),
    .din_i       (din_i),
    .done_o      (done_o),
    .dout_o      (dout_o),
    .arb_lost_o  (arb_lost_o),
    .busy_o      (busy_o),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .scl_oe_o    (scl_oe_o),
    .sda_oe_o    (sda_oe_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef I2CMB_CLK_STRETCH_EN
  localparam int STR_LAT = 21;
`else
  localparam int STR_LAT = 9;
`endif

  typedef struct {
    int   cyc;
    logic arb;
    logic dout;
    logic scl;
    logic sda;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   c0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: every done_o is matched against the oldest expectation
  always @(negedge clk_i) begin
    if (rst_i === 1'b1) begin
      if (done_o) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got 1 want 0 (cyc %0d)", cyc);
        end else begin
          e_m = q.pop_front();
          chk("done_cycle", cyc, e_m.cyc);
          chk("arb_lost", arb_lost_o, e_m.arb);
          chk("dout", dout_o, e_m.dout);
          chk("scl_oe_at_done", scl_oe_o, e_m.scl);
          chk("sda_oe_at_done", sda_oe_o, e_m.sda);
        end
      end else if (arb_lost_o) begin
        total++;
        bad++;
        $display("FAIL arb_without_done: got 1 want 0 (cyc %0d)", cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_q(input int lim);
    int n;
    n = 0;
    while (q.size() != 0 && n < lim) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got none want %0d", q.size());
      q.delete();
    end
  endtask

  // drive one command for a single cycle; expected done at c+lat
  task automatic issue(input logic [1:0] c, input logic d,
                       input logic [15:0] p, input int lat,
                       input logic push, input logic x_arb,
                       input logic x_dout, input logic x_scl,
                       input logic x_sda, output int t0);
    exp_t e;
    chk("ready_at_issue", cmd_ready_o, 1);
    t0 = cyc;
    cmd_valid_i = 1'b1;
    cmd_i = c;
    din_i = d;
    prescale_i = p;
    e.cyc = t0 + lat;
    e.arb = x_arb;
    e.dout = x_dout;
    e.scl = x_scl;
    e.sda = x_sda;
    if (push) q.push_back(e);
    step();
    cmd_valid_i = 1'b0;
    din_i = ~d;
    prescale_i = 16'h00FF;
  endtask

  initial begin
    rst_i = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_i = 2'b00;
    din_i = 1'b0;
    prescale_i = 16'd0;
    step();
    step();
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_dout", dout_o, 0);
    chk("rst_arb", arb_lost_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_scl_oe", scl_oe_o, 0);
    chk("rst_sda_oe", sda_oe_o, 0);
    rst_i = 1'b1;
    step();
    step();
    chk("post_rst_ready", cmd_ready_o, 1);
    chk("post_rst_oe", {scl_oe_o, sda_oe_o}, 0);

    // START, N=4; also a request during the command must be dropped
    issue(2'b00, 1'b0, 16'd3, 17, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, c0);
    wait_cyc(c0 + 5);
    chk("ready_busy_cmd", cmd_ready_o, 0);
    cmd_valid_i = 1'b1;
    cmd_i = 2'b01;
    step();
    cmd_valid_i = 1'b0;
    wait_cyc(c0 + 8);
    chk("start_sda_c8", sda_oe_o, 0);
    wait_cyc(c0 + 9);
    chk("start_sda_c9", sda_oe_o, 1);
    chk("start_scl_c9", scl_oe_o, 0);
    wait_cyc(c0 + 10);
    chk("busy_c10", busy_o, 0);
    wait_cyc(c0 + 12);
    chk("busy_c12", busy_o, 1);
    chk("start_scl_c12", scl_oe_o, 0);
    wait_cyc(c0 + 13);
    chk("start_scl_c13", scl_oe_o, 1);
    wait_q(200);

    // WRITE 0 then READ (released SDA reads 1), back to back at N=1
    issue(2'b10, 1'b0, 16'd0, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, c0);
    wait_cyc(c0 + 5);
    chk("b2b_done_seen", done_o, 1);
    issue(2'b11, 1'b0, 16'd0, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, c0);
    wait_q(200);

    // arbitration: WRITE 1 against a foreign low on SDA, N=3
    ext_sda_lo = 1'b1;
    repeat (4) step();
    issue(2'b10, 1'b1, 16'd2, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c0);
    chk("busy_before_stop", busy_o, 1);
    wait_q(200);
    chk("arb_no_phd_scl", scl_oe_o, 0);
    chk("arb_no_phd_sda", sda_oe_o, 0);
    chk("arb_no_second_done", done_o, 0);
    wait_cyc(c0 + 12);
    ext_sda_lo = 1'b0;
    wait_cyc(c0 + 16);
    chk("busy_after_stop", busy_o, 0);

    // slave holds SCL low into PH_B, N=2
    issue(2'b10, 1'b0, 16'd1, STR_LAT, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, c0);
    ext_scl_lo = 1'b1;
    wait_cyc(c0 + 13);
    ext_scl_lo = 1'b0;
    wait_q(200);

    // reset in PH_C of STOP: lines drop at once, no done
    issue(2'b01, 1'b0, 16'd3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c0);
    wait_cyc(c0 + 10);
    chk("stop_phc_scl", scl_oe_o, 0);
    rst_i = 1'b0;
    #1;
    chk("rst_mid_oe", {scl_oe_o, sda_oe_o}, 0);
    chk("rst_mid_done", done_o, 0);
    wait_cyc(c0 + 13);
    rst_i = 1'b1;
    step();
    chk("rst_mid_ready", cmd_ready_o, 1);
    chk("rst_mid_busy", busy_o, 0);
    repeat (30) step();
    chk("no_pending_exp", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
